// File: rtl/led_blink_device_pkg.sv
// led_dev_pkg: shared constants and types for the LED blink device.
//   LED_OFF_*  : byte offsets of the four registers from BASE
//   reg_sel_e  : decoded register select
// Optional build macro used by the device: LEDDEV_READBACK_EN.
package led_dev_pkg;

    localparam int unsigned LED_OFF_VAL = 0;
    localparam int unsigned LED_OFF_MSK = 4;
    localparam int unsigned LED_OFF_PER = 8;
    localparam int unsigned LED_OFF_OUT = 12;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_VAL,
        SEL_MSK,
        SEL_PER,
        SEL_OUT
    } reg_sel_e;

endpackage

// File: rtl/led_blink_device_if.sv
// led_blink_device_if: processor peripheral bus (ABUS/DBUS/WE/FLUSH).
//   ABUS  : address, driven by the master
//   WE    : write enable, driven by the master
//   FLUSH : pipeline flush, suppresses device select
//   DBUS  : shared tri-state data bus
interface led_blink_device_if #(
    parameter int unsigned BITS = 32
);
    logic [BITS-1:0] ABUS;
    logic            WE;
    logic            FLUSH;
    // Resolved net: several devices and the master share it.
    wire  [BITS-1:0] DBUS;

    modport master (output ABUS, output WE, output FLUSH, inout DBUS);
    modport slave  (input  ABUS, input  WE, input  FLUSH, inout DBUS);
endinterface

// File: rtl/led_blink_device_blink_timer.sv
// blink_timer: free-running blink half-period timer.
//   CLK   : clock
//   RESET : asynchronous active-high reset
//   clr   : synchronous clear of counter and phase (LOCK low or PER write)
//   per   : half-period in CLK cycles; 0 freezes the timer
//   phase : blink phase, toggles every 'per' cycles
module blink_timer #(
    parameter int unsigned PBITS = 24
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             clr,
    input  logic [PBITS-1:0] per,
    output logic             phase
);
    logic [PBITS-1:0] cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (clr) begin
            // Clear wins over a wrap on the same edge.
            cnt   <= '0;
            phase <= 1'b0;
        end else if (per != '0) begin
            if (cnt == per - PBITS'(1)) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt   <= cnt + PBITS'(1);
            end
        end
    end
endmodule

// File: rtl/led_blink_device.sv
// led_blink_device: memory-mapped LED output with hardware blinking.
//   CLK   : system clock
//   RESET : asynchronous active-high reset
//   bus   : peripheral bus (slave side): ABUS, DBUS, WE, FLUSH
//   LOCK  : PLL lock; low clears all registers synchronously
//   LED   : LED drive, VAL ^ (MSK & phase)
// Registers at BASE: +0 VAL, +4 MSK, +8 PER, +12 OUT (read-only).
// Build macro LEDDEV_READBACK_EN enables DBUS readback; without it the
// device never drives DBUS.
module led_blink_device
    import led_dev_pkg::*;
#(
    parameter int unsigned    BITS  = 32,
    parameter int unsigned    LBITS = 10,
    parameter int unsigned    PBITS = 24,
    parameter logic [BITS-1:0] BASE = 32'hF0000000
) (
    input  logic               CLK,
    input  logic               RESET,
    led_blink_device_if.slave  bus,
    input  logic               LOCK,
    output logic [LBITS-1:0]   LED
);
    logic [LBITS-1:0] val;
    logic [LBITS-1:0] msk;
    logic [PBITS-1:0] per;
    logic             phase;
    logic             per_wr;
    reg_sel_e         sel;

    always_comb begin
        sel = SEL_NONE;
        if (!bus.FLUSH) begin
            if      (bus.ABUS == BASE + BITS'(LED_OFF_VAL)) sel = SEL_VAL;
            else if (bus.ABUS == BASE + BITS'(LED_OFF_MSK)) sel = SEL_MSK;
            else if (bus.ABUS == BASE + BITS'(LED_OFF_PER)) sel = SEL_PER;
            else if (bus.ABUS == BASE + BITS'(LED_OFF_OUT)) sel = SEL_OUT;
        end
    end

    assign per_wr = bus.WE && (sel == SEL_PER);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            val <= '0;
            msk <= '0;
            per <= '0;
        end else if (!LOCK) begin
            val <= '0;
            msk <= '0;
            per <= '0;
        end else if (bus.WE) begin
            case (sel)
                SEL_VAL: val <= bus.DBUS[LBITS-1:0];
                SEL_MSK: msk <= bus.DBUS[LBITS-1:0];
                SEL_PER: per <= bus.DBUS[PBITS-1:0];
                default: ;
            endcase
        end
    end

    blink_timer #(
        .PBITS (PBITS)
    ) u_timer (
        .CLK   (CLK),
        .RESET (RESET),
        .clr   (!LOCK || per_wr),
        .per   (per),
        .phase (phase)
    );

    assign LED = val ^ (msk & {LBITS{phase}});

`ifdef LEDDEV_READBACK_EN
    logic [BITS-1:0] rdata;
    logic            rd_en;

    always_comb begin
        rdata = '0;
        case (sel)
            SEL_VAL: rdata[LBITS-1:0] = val;
            SEL_MSK: rdata[LBITS-1:0] = msk;
            SEL_PER: rdata[PBITS-1:0] = per;
            SEL_OUT: rdata[LBITS-1:0] = LED;
            default: ;
        endcase
    end

    // Release the bus at once while RESET is high, without waiting for CLK.
    assign rd_en    = (sel != SEL_NONE) && !bus.WE && !RESET;
    assign bus.DBUS = rd_en ? rdata : 'z;
`else
    // Write-only build: DBUS is never driven by this device.
`endif
endmodule
